// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the small CPU slice: opcode constants used by the
// decoder, instruction field widths, the default program counter width and
// the encoding of the fetch unit state machine.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Instruction byte layout: upper 5 bits opcode, lower 3 bits operand
    localparam int OPCODE_W  = 5;
    localparam int OPERAND_W = 3;
    localparam int INSTR_W   = OPCODE_W + OPERAND_W;

    // Default instruction address width
    localparam int PC_W_DEFAULT = 8;

    // Opcodes (formerly private to the decoder source)
    localparam logic [OPCODE_W-1:0] OP_LI  = 5'h01;
    localparam logic [OPCODE_W-1:0] OP_LD  = 5'h02;
    localparam logic [OPCODE_W-1:0] OP_ST  = 5'h03;
    localparam logic [OPCODE_W-1:0] OP_INC = 5'h11;

    // Fetch state encoding, 3-bit binary
    localparam int FETCH_STATE_W = 3;
    localparam logic [FETCH_STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [FETCH_STATE_W-1:0] ST_FETCH    = 3'd1;
    localparam logic [FETCH_STATE_W-1:0] ST_ISSUE    = 3'd2;
    localparam logic [FETCH_STATE_W-1:0] ST_WAIT_MEM = 3'd3;
    localparam logic [FETCH_STATE_W-1:0] ST_HALTED   = 3'd4;

    // True when the instruction needs the data-memory path
    function automatic logic is_mem_op(input logic [INSTR_W-1:0] instr);
        logic [OPCODE_W-1:0] opcode;
        opcode = instr[INSTR_W-1:OPERAND_W];
        return (opcode == OP_LD) || (opcode == OP_ST);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request bus between the fetch unit and memory.
//   imem_req    fetch request valid (fetch unit -> memory)
//   imem_addr   fetch address       (fetch unit -> memory)
//   imem_ready  memory accepts and returns data this cycle (memory -> fetch)
//   imem_rdata  instruction byte, valid with imem_req & imem_ready
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [7:0]      imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end. Owns the program counter, requests bytes from
// instruction memory with a valid/ready handshake, presents each byte to the
// decoder for one issue cycle and then follows the decoder feedback
// (advance, jump, or wait for a data-memory op to complete).
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   imem          instruction-memory bus (master side)
//   instr         held instruction byte to the decoder
//   instr_valid   one-cycle issue strobe for instr
//   pc            address of the instruction currently in instr
//   increment_pc  decoder feedback: non-memory op, advance now
//   mem_done      data-memory op completed (only looked at in WAIT_MEM)
//   jump_en       taken jump (looked at in ISSUE and WAIT_MEM)
//   jump_target   jump destination
//   halt          stop fetching after the current instruction retires
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_unit_if.master         imem,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    output logic [PC_W-1:0]      pc,
    input  logic                 increment_pc,
    input  logic                 mem_done,
    input  logic                 jump_en,
    input  logic [PC_W-1:0]      jump_target,
    input  logic                 halt
);

    logic [FETCH_STATE_W-1:0] state;
    logic [FETCH_STATE_W-1:0] state_next;
    logic [PC_W-1:0]          pc_next;
    logic [INSTR_W-1:0]       instr_next;
    logic [FETCH_STATE_W-1:0] retire_state;

    // Bus outputs come only from registered state, so there is no
    // combinational path from any input to the memory request.
    assign imem.imem_req  = (state == ST_FETCH);
    assign imem.imem_addr = pc;
    assign instr_valid    = (state == ST_ISSUE);

    // Where to go once the current instruction retires; halt is only
    // honoured here, so a halt seen earlier waits for the retire.
    assign retire_state = halt ? ST_HALTED : ST_FETCH;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    instr_next = imem.imem_rdata;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A taken jump overrides the decoder's advance request
                if (jump_en) begin
                    pc_next    = jump_target;
                    state_next = retire_state;
                end else if (increment_pc) begin
                    pc_next    = pc + PC_W'(1);
                    state_next = retire_state;
                end else begin
                    state_next = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_done) begin
                    pc_next    = jump_en ? jump_target : pc + PC_W'(1);
                    state_next = retire_state;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            instr <= instr_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A program-level model tracks which
// address must issue next (pc+1, jump target, or after a memory op) and
// checks the DUT every falling edge; directed tests add literal checks.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import cpu_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic       instr_valid;
    logic [7:0] pc;
    logic       increment_pc;
    logic       mem_done;
    logic       jump_en;
    logic [7:0] jump_target;
    logic       halt;
    logic       ready_r;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fetch_unit_if #(.PC_W(8)) imem_bus ();

    assign imem_bus.imem_ready = ready_r;
    assign imem_bus.imem_rdata = mem[imem_bus.imem_addr];

    // Combinational decoder stand-in: non-memory ops request an advance
    assign increment_pc = instr_valid && !is_mem_op(instr);

    fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (imem_bus.master),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .increment_pc (increment_pc),
        .mem_done     (mem_done),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .halt         (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Program-level model: exp_pc is the address that must issue next
    logic [7:0] exp_pc;
    logic       model_wait;
    logic       model_halted;
    logic       prev_valid;

    initial begin
        exp_pc = 8'h00; model_wait = 1'b0; model_halted = 1'b0; prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_pc = 8'h00; model_wait = 1'b0; model_halted = 1'b0; prev_valid = 1'b0;
            end else begin
                if (instr_valid)
                    check_output("valid_spacing", {31'd0, prev_valid}, 32'd0);
                if (model_halted) begin
                    check_output("halted_req", {31'd0, imem_bus.imem_req}, 32'd0);
                    check_output("halted_valid", {31'd0, instr_valid}, 32'd0);
                end else if (model_wait) begin
                    check_output("wait_req", {31'd0, imem_bus.imem_req}, 32'd0);
                    check_output("wait_valid", {31'd0, instr_valid}, 32'd0);
                    check_output("wait_pc", {24'd0, pc}, {24'd0, exp_pc});
                    if (mem_done) begin
                        exp_pc = jump_en ? jump_target : exp_pc + 8'd1;
                        model_wait = 1'b0;
                        if (halt) model_halted = 1'b1;
                    end
                end else begin
                    if (imem_bus.imem_req)
                        check_output("fetch_addr", {24'd0, imem_bus.imem_addr}, {24'd0, exp_pc});
                    if (instr_valid) begin
                        check_output("issue_pc", {24'd0, pc}, {24'd0, exp_pc});
                        check_output("issue_instr", {24'd0, instr}, {24'd0, mem[exp_pc]});
                        if (jump_en || increment_pc) begin
                            exp_pc = jump_en ? jump_target : exp_pc + 8'd1;
                            if (halt) model_halted = 1'b1;
                        end else begin
                            model_wait = 1'b1;
                        end
                    end
                end
                prev_valid = instr_valid;
            end
        end
    end

    // Hold reset for two cycles with quiet inputs and check reset values
    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        ready_r = 1'b1; mem_done = 1'b0; jump_en = 1'b0; jump_target = 8'h00; halt = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check_output("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_output("rst_pc", {24'd0, pc}, 32'h00);
        check_output("rst_instr", {24'd0, instr}, 32'h00);
    endtask

    task automatic apply_stimulus_release();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Wait (bounded) for the next issue strobe and check it literally
    task automatic wait_issue(input logic [7:0] epc, input logic [7:0] einstr, output int at_cyc);
        bit seen;
        seen = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid) seen = 1'b1;
        end
        if (!seen) begin
            check_output("issue_timeout", 32'd0, 32'd1);
        end else begin
            at_cyc = cyc;
            check_output("lit_issue_pc", {24'd0, pc}, {24'd0, epc});
            check_output("lit_issue_instr", {24'd0, instr}, {24'd0, einstr});
        end
    endtask

    task automatic check_fetch(input string name, input logic [7:0] eaddr);
        check_output({name, "_req"}, {31'd0, imem_bus.imem_req}, 32'd1);
        check_output({name, "_addr"}, {24'd0, imem_bus.imem_addr}, {24'd0, eaddr});
    endtask

    initial begin
        int c0, c1, c2;
        reset = 1'b0; ready_r = 1'b1; mem_done = 1'b0; jump_en = 1'b0;
        jump_target = 8'h00; halt = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h09;

        // Back-to-back non-memory ops with zero-wait memory
        mem[0] = 8'h09; mem[1] = 8'h0A; mem[2] = 8'h8B;
        apply_reset();
        apply_stimulus_release();
        @(negedge clk);
        check_output("dead_cycle_req", {31'd0, imem_bus.imem_req}, 32'd0);
        @(negedge clk);
        check_fetch("first_fetch", 8'h00);
        wait_issue(8'h00, 8'h09, c0);
        wait_issue(8'h01, 8'h0A, c1);
        wait_issue(8'h02, 8'h8B, c2);
        check_output("issue_gap_1", c1 - c0, 32'd2);
        check_output("issue_gap_2", c2 - c1, 32'd2);

        // Memory wait states on the first fetch
        mem[0] = 8'h0A;
        apply_reset();
        ready_r = 1'b0;
        apply_stimulus_release();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_fetch("stall_fetch", 8'h00);
            check_output("stall_instr", {24'd0, instr}, 32'h00);
        end
        @(posedge clk); #1;
        ready_r = 1'b1;
        @(negedge clk);
        check_fetch("stall_last", 8'h00);
        wait_issue(8'h00, 8'h0A, c0);

        // Load instruction waits for mem_done
        mem[0] = 8'h12; mem[1] = 8'h09;
        apply_reset();
        apply_stimulus_release();
        wait_issue(8'h00, 8'h12, c0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 4) mem_done = 1'b1;
            @(negedge clk);
            check_output("ld_wait_req", {31'd0, imem_bus.imem_req}, 32'd0);
            check_output("ld_wait_pc", {24'd0, pc}, 32'h00);
        end
        @(posedge clk); #1;
        mem_done = 1'b0;
        @(negedge clk);
        check_fetch("after_ld", 8'h01);
        wait_issue(8'h01, 8'h09, c0);

        // PC wrap from 8'hFF; jump is ignored outside ISSUE/WAIT_MEM
        mem[0] = 8'h09; mem[8'hFF] = 8'h8B;
        apply_reset();
        jump_en = 1'b1; jump_target = 8'hFF;
        apply_stimulus_release();
        wait_issue(8'h00, 8'h09, c0);
        @(posedge clk); #1;
        jump_en = 1'b0;
        @(negedge clk);
        check_fetch("jump_ff", 8'hFF);
        wait_issue(8'hFF, 8'h8B, c0);
        @(negedge clk);
        check_fetch("wrap", 8'h00);
        wait_issue(8'h00, 8'h09, c0);

        // Jump beats increment in ISSUE, and wins over pc+1 in WAIT_MEM
        mem[0] = 8'h09; mem[8'h40] = 8'h12;
        apply_reset();
        jump_en = 1'b1; jump_target = 8'h40;
        apply_stimulus_release();
        wait_issue(8'h00, 8'h09, c0);
        @(posedge clk); #1;
        jump_en = 1'b0;
        @(negedge clk);
        check_fetch("jump_issue", 8'h40);
        wait_issue(8'h40, 8'h12, c0);
        @(posedge clk); #1;
        jump_en = 1'b1; mem_done = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        jump_en = 1'b0; mem_done = 1'b0;
        @(negedge clk);
        check_fetch("jump_wait", 8'h40);
        wait_issue(8'h40, 8'h12, c0);

        // Halt raised before issue is deferred, then holds until reset
        mem[0] = 8'h09;
        apply_reset();
        halt = 1'b1;
        apply_stimulus_release();
        wait_issue(8'h00, 8'h09, c0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 5) halt = 1'b0;
            @(negedge clk);
            check_output("halt_req", {31'd0, imem_bus.imem_req}, 32'd0);
        end
        check_output("halt_pc", {24'd0, pc}, 32'h01);

        // Asynchronous reset in the middle of a stalled fetch
        mem[0] = 8'h0A;
        apply_reset();
        ready_r = 1'b0; jump_en = 1'b1; jump_target = 8'h33;
        apply_stimulus_release();
        @(negedge clk);
        @(posedge clk); #1;
        jump_en = 1'b0;
        @(negedge clk);
        check_fetch("pre_abort", 8'h00);
        #2;
        reset = 1'b0;
        #1;
        check_output("abort_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check_output("abort_pc", {24'd0, pc}, 32'h00);
        ready_r = 1'b1;
        @(negedge clk);
        apply_stimulus_release();
        @(negedge clk);
        @(negedge clk);
        check_fetch("restart", 8'h00);
        wait_issue(8'h00, 8'h0A, c0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that produces the 8-bit `instr` byte consumed by the decoder.
- Owns the program counter and runs a valid/ready request handshake to instruction memory.
- Presents each fetched byte to the decoder for exactly one issue cycle, then reacts to the decoder's `increment_pc` feedback.
- Stalls on memory ops until the data-memory path reports completion; supports taken jumps.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded at reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request valid to instruction memory
imem_addr  output  PC_W  fetch address; equals pc while imem_req=1
imem_ready  input  1  memory accepts and returns data this cycle
imem_rdata  input  8  instruction byte; valid when imem_req & imem_ready
instr  output  8  held instruction byte to decoder
instr_valid  output  1  one-cycle issue strobe for instr
pc  output  PC_W  address of the instruction currently in instr
increment_pc  input  1  decoder feedback: non-memory op, advance now
mem_done  input  1  data-memory op completed (used in WAIT_MEM only)
jump_en  input  1  taken jump; sampled in ISSUE and WAIT_MEM
jump_target  input  PC_W  jump destination
halt  input  1  stop fetching after the current instruction retires

Behaviour:
- Reset (reset=0, asynchronous) drives these values: state=IDLE, pc=RESET_PC, instr=8'h00, instr_valid=0, imem_req=0.
- States: IDLE, FETCH, ISSUE, WAIT_MEM, HALTED. Encoding is 3 bits, binary.
- IDLE: on the first clk edge after reset deasserts, go to FETCH. There is exactly one dead cycle.
- FETCH: imem_req=1, imem_addr=pc.
  - If imem_ready=1: instr<=imem_rdata, go to ISSUE.
  - Otherwise hold in FETCH with imem_req high and the address stable.
  - Minimum fetch latency is 1 cycle.
- ISSUE: instr_valid=1 for this single cycle; instr and pc are stable. The decoder is combinational, so increment_pc is sampled in this cycle.
  - jump_en=1 has top priority: pc<=jump_target; go to FETCH (or HALTED if halt=1).
  - Else if increment_pc=1: pc<=pc+1; go to FETCH (or HALTED if halt=1).
  - Else (memory op): go to WAIT_MEM with pc unchanged.
- WAIT_MEM: instr_valid=0; instr and pc are held.
  - If mem_done=1: pc<=pc+1 (or jump_target if jump_en=1); go to FETCH (or HALTED if halt=1).
  - Otherwise stay in WAIT_MEM.
  - mem_done is ignored in every other state.
- HALTED: imem_req=0, instr_valid=0. Stays here until reset; halt deassertion does not resume.
- halt sampled in FETCH or IDLE is deferred: the current instruction still completes ISSUE/WAIT_MEM first.
- PC arithmetic is modulo 2^PC_W: pc=8'hFF plus 1 gives 8'h00, with no flag.
- Issue rate: a back-to-back non-memory sequence with zero-wait memory issues one instruction every 2 cycles (FETCH, ISSUE).
- imem_addr and imem_req are registered-state-derived, with no combinational path from inputs.
- Asynchronous reset mid-handshake (FETCH with imem_ready low) drops imem_req the same instant. Memory must tolerate an abandoned request.
- instr_valid is never high in two consecutive cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_LI, OP_LD, OP_ST, OP_INC, moved out of the decoder source;
  - instruction field widths (opcode 5, operand 3);
  - PC_W default;
  - fetch state encoding localparams.
- No sub-module: PC register, instruction register and FSM stay in one module (~150–200 lines).

Test Plan:
- Reset release, imem_ready tied high, memory holds 8'h09,8'h0A,8'h8B (LI/INC-type) -> imem_addr 0,1,2; instr_valid pulses every 2nd cycle; instr=8'h09,8'h0A,8'h8B; pc=0,1,2.
- imem_ready held low 3 cycles at addr 0 -> imem_req high and imem_addr=0 steady 4 cycles; instr captured only on the ready cycle; one instr_valid pulse.
- Instr 8'h12 (LD), increment_pc=0, mem_done after 5 cycles -> WAIT_MEM for 5 cycles, pc stays 0, no imem_req; the next fetch has imem_addr=1.
- pc=8'hFF non-memory instr -> next imem_addr=8'h00.
- jump_en=1, jump_target=8'h40 with increment_pc=1 in ISSUE -> next imem_addr=8'h40 (jump wins). Repeat in WAIT_MEM with mem_done=1 -> 8'h40.
- Cases to cover:
  - halt=1 during ISSUE -> HALTED, imem_req stays 0 for 20 cycles.
  - reset pulled low mid-FETCH -> imem_req drops immediately, pc=RESET_PC; after release, fetch restarts at addr 0.
